fetch_unit: RTL and testbench

Instruction-fetch front end of the pipelined MIPS datapath. It owns the program counter, issues requests to the instruction memory over a grant/valid handshake, and loads the IF/ID pipeline register consumed by decode. It honours stall and branch-redirect requests from the hazard/branch logic, and stops the machine on the all-ones halt word.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/if_skid_buffer.sv | 35 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch states, special
// instruction words and the IF/ID bundle consumed by decode.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    function automatic logic is_halt(input logic [31:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit.
// Handshake: a request is accepted at a rising edge where imem_req and imem_gnt
// are both high; exactly one imem_rvalid pulse (carrying imem_rdata) answers it,
// and at most one request is outstanding at any time.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not take yet.
// Flush beats load, load beats drain.
module if_skid_buffer
    import mips_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_drain,
    input  logic   i_flush,
    input  if_id_t i_data,
    output if_id_t o_data,
    output logic   o_valid
);

    if_id_t r_data;
    logic   r_valid;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, talks to instruction memory and
// loads the IF/ID register, honouring stall, redirect and the halt word.
module fetch_unit
    import mips_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         if_id_instr,
    output logic [31:0]         if_id_pc4,
    output logic                if_id_valid,
    output logic                halted,
    output fetch_state_e        o_dbg_state
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_kill, w_kill_nxt;
    if_id_t       r_if_id, w_if_id_nxt;
    logic         r_if_id_valid, w_if_id_valid_nxt;
    logic         r_halted, w_halted_nxt;

    logic         w_acc;
    logic         w_consumed;
    logic         w_req;
    logic         w_deliver;
    if_id_t       w_deliver_data;
    logic         w_skid_load;
    logic         w_skid_drain;
    logic         w_skid_flush;
    if_id_t       w_skid_data;
    logic         w_skid_valid;

    if_skid_buffer u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_flush (w_skid_flush),
        .i_data  ('{instr: imem.imem_rdata, pc4: r_pc}),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    always_comb begin
        w_acc             = !r_if_id_valid || !stall;
        w_consumed        = r_if_id_valid && !stall;
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_kill_nxt        = r_kill;
        w_if_id_nxt       = r_if_id;
        w_if_id_valid_nxt = w_consumed ? 1'b0 : r_if_id_valid;
        w_halted_nxt      = r_halted;
        w_req             = 1'b0;
        w_deliver         = 1'b0;
        w_deliver_data    = '{instr: NOP_WORD, pc4: 32'h0};
        w_skid_load       = 1'b0;
        w_skid_drain      = 1'b0;
        w_skid_flush      = 1'b0;

        case (r_state)
            S_REQ: begin
                // No request goes out while a redirect is retargeting the PC.
                w_req = !redirect;
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end else if (imem.imem_gnt) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect && !imem.imem_rvalid) begin
                    w_pc_nxt   = redirect_pc;
                    w_kill_nxt = 1'b1;
                end else if (imem.imem_rvalid && (r_kill || redirect)) begin
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                    if (redirect) begin
                        w_pc_nxt = redirect_pc;
                    end
                end else if (imem.imem_rvalid) begin
                    if (w_acc) begin
                        w_deliver      = 1'b1;
                        w_deliver_data = '{instr: imem.imem_rdata, pc4: r_pc};
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_skid_flush = 1'b1;
                    w_pc_nxt     = redirect_pc;
                    w_state_nxt  = S_REQ;
                end else if (w_acc && w_skid_valid) begin
                    w_skid_drain   = 1'b1;
                    w_deliver      = 1'b1;
                    w_deliver_data = w_skid_data;
                end
            end
            S_HALT: begin
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        // The halt word stops fetch and is never handed to decode.
        if (w_deliver) begin
            if (is_halt(w_deliver_data.instr)) begin
                w_halted_nxt = 1'b1;
                w_state_nxt  = S_HALT;
            end else begin
                w_if_id_nxt       = w_deliver_data;
                w_if_id_valid_nxt = 1'b1;
                w_state_nxt       = S_REQ;
            end
        end

        if (redirect && r_state != S_HALT) begin
            w_if_id_valid_nxt   = 1'b0;
            w_if_id_nxt.instr   = NOP_WORD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_if_id       <= '{instr: NOP_WORD, pc4: 32'h0};
            r_if_id_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_if_id       <= w_if_id_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign imem.imem_req  = w_req && !reset;
    assign imem.imem_addr = r_pc;
    assign if_id_instr    = r_if_id.instr;
    assign if_id_pc4      = r_if_id.pc4;
    assign if_id_valid    = r_if_id_valid;
    assign halted         = r_halted;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level model of the fetch
// front end and a scripted instruction memory.
module tb_fetch_unit;
    import mips_pkg::*;

    logic         clock;
    logic         reset;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  if_id_instr;
    logic [31:0]  if_id_pc4;
    logic         if_id_valid;
    logic         halted;
    fetch_state_e dbg_state;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: contents, latency and one pending response
    logic [31:0] mem [logic [31:0]];
    int          lat = 0;
    logic        gnt_en = 1'b1;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h2000_0000 | a;
    endfunction

    task automatic tick();
        logic        fire;
        logic [31:0] fire_addr;
        #1;
        bus.imem_gnt = bus.imem_req && gnt_en;
        fire      = bus.imem_gnt;
        fire_addr = bus.imem_addr;
        @(posedge clock);
        #1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        if (fire) begin
            pend      = 1'b1;
            pend_addr = fire_addr;
            pend_cnt  = lat;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr);
                pend            = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input logic [31:0] a, input string name);
        int n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'b0, bus.imem_req && bus.imem_addr == a}, 32'd1);
    endtask

    // Model: PC, one outstanding fetch (possibly doomed), at most one parked
    // word, the IF/ID contents and the halt flag.
    logic [31:0] m_pc = RESET_PC;
    logic        m_outstanding = 1'b0;
    logic        m_drop = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;
    logic [63:0] exp_q [$];

    function automatic logic m_req_phase();
        return !m_halted && !m_outstanding && exp_q.size() == 0;
    endfunction

    task automatic deliver(input logic [63:0] e);
        if (e[63:32] == 32'hFFFF_FFFF) begin
            m_halted = 1'b1;
        end else begin
            m_valid = 1'b1;
            m_instr = e[63:32];
            m_pc4   = e[31:0];
        end
    endtask

    always @(posedge clock) begin
        logic accept;
        if (reset) begin
            m_pc = RESET_PC; m_outstanding = 1'b0; m_drop = 1'b0; m_halted = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
            exp_q.delete();
        end else begin
            accept = !m_valid || !stall;
            if (m_valid && !stall) m_valid = 1'b0;
            if (m_halted) begin
            end else if (redirect) begin
                m_valid = 1'b0;
                m_instr = 32'h0;
                if (m_outstanding) begin
                    if (bus.imem_rvalid) begin
                        m_outstanding = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                exp_q.delete();
                m_pc = redirect_pc;
            end else if (exp_q.size() != 0) begin
                if (accept) deliver(exp_q.pop_front());
            end else if (m_outstanding) begin
                if (bus.imem_rvalid) begin
                    m_outstanding = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else if (accept) deliver({bus.imem_rdata, m_pc});
                    else exp_q.push_back({bus.imem_rdata, m_pc});
                end
            end else if (bus.imem_gnt) begin
                m_outstanding = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        logic exp_req;
        if (cmp_en) begin
            exp_req = m_req_phase() && !reset && !redirect;
            check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
            if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
            check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check("if_id_instr", if_id_instr, m_instr);
            if (m_valid) check("if_id_pc4", if_id_pc4, m_pc4);
            check("halted", {31'b0, halted}, {31'b0, m_halted});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        mem[32'h00] = 32'h8C01_0000;
        mem[32'h04] = 32'h0022_1820;
        mem[32'h08] = 32'h0001_1020;
        mem[32'h0C] = 32'hAC03_0004;
        mem[32'h10] = 32'h1000_0005;
        mem[32'h40] = 32'h2004_0040;

        @(posedge clock); #1;
        tick();
        cmp_en = 1'b1;
        check("reset_valid", {31'b0, if_id_valid}, 32'd0);
        check("reset_instr", if_id_instr, 32'h0);
        check("reset_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        reset = 1'b0;

        // Zero-wait fetch of two words
        check("first_addr", bus.imem_addr, 32'h0);
        ticks(2);
        check("w0_instr", if_id_instr, 32'h8C01_0000);
        check("w0_pc4", if_id_pc4, 32'h4);
        tick();
        check("gap_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        check("w1_instr", if_id_instr, 32'h0022_1820);
        check("w1_pc4", if_id_pc4, 32'h8);

        // Stall for three cycles while the 0x8 response arrives
        stall = 1'b1;
        ticks(2);
        check("skid_state", {30'b0, dbg_state}, {30'b0, S_HOLD});
        check("stall_instr", if_id_instr, 32'h0022_1820);
        tick();
        stall = 1'b0;
        tick();
        check("w2_instr", if_id_instr, 32'h0001_1020);
        check("w2_pc4", if_id_pc4, 32'hC);

        // Redirect while the 0x10 fetch is in flight
        lat = 1;
        wait_req(32'h10, "reach_0x10");
        tick();
        lat = 0;
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("redir_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        check("redir_addr", bus.imem_addr, 32'h40);
        ticks(2);
        check("w40_instr", if_id_instr, 32'h2004_0040);
        check("w40_pc4", if_id_pc4, 32'h44);

        // Redirect and stall together: flush wins
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check("flush_valid", {31'b0, if_id_valid}, 32'd0);
        check("flush_addr", bus.imem_addr, 32'h80);

        // Halt word at 0xC
        mem[32'h0C] = 32'hFFFF_FFFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 30 && !halted; n++) tick();
        check("halt_seen", {31'b0, halted}, 32'd1);
        for (int n = 0; n < 20; n++) begin
            redirect = (n >= 5 && n < 8);
            redirect_pc = 32'h100;
            stall = (n == 10);
            tick();
            check("halt_no_req", {31'b0, bus.imem_req}, 32'd0);
            check("halt_not_loaded", {31'b0, if_id_instr == 32'hFFFF_FFFF}, 32'd0);
        end
        redirect = 1'b0; stall = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("restart_addr", bus.imem_addr, 32'h0);
        check("restart_halted", {31'b0, halted}, 32'd0);

        // Reset while a word is parked, then a stray response
        stall = 1'b1;
        ticks(4);
        check("hold_before_reset", {30'b0, dbg_state}, {30'b0, S_HOLD});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gnt_en = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        tick();
        check("late_state", {30'b0, dbg_state}, {30'b0, S_REQ});
        check("late_valid", {31'b0, if_id_valid}, 32'd0);
        stall = 1'b0; gnt_en = 1'b1;
        ticks(2);
        check("after_late_instr", if_id_instr, 32'h8C01_0000);
        check("after_late_pc4", if_id_pc4, 32'h4);
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
